switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Conditions the raw asynchronous `pin_switch` inputs before they drive the mother board's `io_bus.switch`.
- Sits between the board pins and the I/O bus, in the fast board clock domain.
- Per bit, it synchronises the input, rejects bounce shorter than a programmable stable window, and presents a clean registered level.
- It also presents a one-cycle "changed" strobe, so the slow CPU domain sees no glitches or metastability.

Parameters:
- WIDTH, 4, number of switch bits conditioned independently.
- STABLE_CYCLES, 1_000_000, clocks a new synchronised level must persist before it is accepted (10 ms at 100 MHz); legal range 1 to 2^24.
- SYNC_STAGES, 2, depth of the synchroniser flop chain per bit; legal range 2 to 4.
- RESET_VALUE, '0, WIDTH-bit value loaded into the synchroniser and the stable output at reset.

Ports:
- clock  input  1  board clock; all state updates on its rising edge.
- n_reset  input  1  reset; asynchronous and active-low.
- raw_switch  input  WIDTH  asynchronous switch pins.
- switch  output  WIDTH  debounced, registered switch level.
- changed  output  WIDTH  one-cycle pulse per bit when that bit of `switch` updates.

Behaviour:
- Reset (`n_reset`=0, asynchronous):
  - Every synchroniser stage is loaded with RESET_VALUE.
  - `switch` = RESET_VALUE.
  - `changed` = 0.
  - All counters = 0.
  - All bit FSMs go to IDLE.
  - Release is synchronous in effect: the first update occurs on the first rising edge with `n_reset`=1.
- Synchroniser: `raw_switch[i]` passes through SYNC_STAGES flops; the last stage is `sync[i]`. No logic sits between stages.
- Per-bit FSM, states IDLE and COUNT:
  - IDLE: counter held at 0. If `sync[i]` != `switch[i]`, go to COUNT with counter = 1.
  - COUNT, `sync[i]` == `switch[i]` (bounce back): go to IDLE, counter = 0, `switch[i]` unchanged, no pulse.
  - COUNT, `sync[i]` != `switch[i]` and counter < STABLE_CYCLES: counter increments.
  - COUNT, `sync[i]` != `switch[i]` and counter == STABLE_CYCLES: on that edge `switch[i]` <= `sync[i]`, `changed[i]` = 1 for exactly that next cycle, counter = 0, go to IDLE.
- Counter width: $clog2(STABLE_CYCLES+1) bits. The counter never wraps; it saturates by construction because the FSM leaves COUNT at STABLE_CYCLES.
- Latency: a clean level change on `raw_switch[i]` appears on `switch[i]` exactly SYNC_STAGES + STABLE_CYCLES + 1 rising edges after the first edge that samples the new level.
- `changed` is registered and asserted in the same cycle `switch` shows the new value. It is never asserted two consecutive cycles for one bit.
- Bits are fully independent. Simultaneous changes on several bits yield simultaneous `changed` pulses when their windows end together.
- Reset mid-count: the count is discarded, `switch` returns to RESET_VALUE, and no pulse is produced.
- A bounce whose opposite level persists fewer than STABLE_CYCLES+1 synchronised cycles never reaches `switch`.
- If the input toggles continuously with period ≤ STABLE_CYCLES, `switch` holds its old value indefinitely. This is required behaviour.

Optional Feature:
- Macro SWITCH_DEBOUNCER_EDGE_EN.
- Defined:
  - Two extra output ports, `rise` WIDTH and `fall` WIDTH, are added after `changed`.
  - `rise[i]` = `changed[i]` & new `switch[i]`; `fall[i]` = `changed[i]` & ~new `switch[i]`.
  - Both are registered, one-cycle pulses, and 0 at reset.
- Undefined:
  - The ports are absent and no edge logic is synthesised.
  - All other behaviour is identical.

Test Plan (bench uses STABLE_CYCLES=8, SYNC_STAGES=2, WIDTH=4, RESET_VALUE=4'b0000):
- Reset: hold `n_reset`=0 with `raw_switch`=4'b1111 → `switch`=4'b0000 and `changed`=0 throughout reset and for 10 edges after release. `switch` becomes 4'b1111 at edge 11 after release, with `changed`=4'b1111 for that single cycle.
- Clean press: `raw_switch` 0→4'b0001 and held → `switch[0]` rises exactly 11 edges after the first sampling edge. `changed`=4'b0001 for one cycle; other bits stay 0.
- Bounce rejection: bit 1 pulses high for 5 cycles, low 3, high 7, then low → `switch`=0 and `changed`=0 for the entire sequence and 20 cycles after.
- Independent bits: bit 2 rises at t, bit 3 rises at t+3 → `changed`=4'b0100 at t+11, then 4'b1000 at t+14; `switch`=4'b1100 afterward.
- Reset mid-count: bit 0 high for 6 cycles, then `n_reset` pulsed low for 1 cycle while `raw_switch` stays high → no `changed` pulse before reset. After release, a full 11-edge latency restarts from the reset release.
- With SWITCH_DEBOUNCER_EDGE_EN: press then release bit 3, each held 20 cycles → `rise`=4'b1000 for one cycle on press acceptance and `fall`=4'b1000 for one cycle on release acceptance; they never overlap with each other.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions asynchronous board switch pins for the I/O bus.
// Each bit passes through a SYNC_STAGES-deep synchroniser. A two-state FSM per
// bit then accepts a new level only after it has persisted for STABLE_CYCLES
// clocks. The accepted level is presented on a registered output, together
// with a one-cycle `changed` strobe.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN adds registered `rise` and
// `fall` pulse outputs after `changed`.
// Observation point: the per-bit FSM state is g_bit[i].state_q
// (IDLE / COUNT), with the matching counter in g_bit[i].cnt_q.
module switch_debouncer #(
  parameter int               WIDTH         = 4,
  parameter int               STABLE_CYCLES = 1_000_000,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] raw_switch,
  output logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] changed
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  // The counter only has to reach STABLE_CYCLES. The FSM leaves COUNT at
  // that value, so the counter can never wrap.
  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("switch_debouncer: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << 24)) begin : g_bad_stable_cycles
    $error("switch_debouncer: STABLE_CYCLES must be 1..2^24");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  // Plain flop chain with no logic between the stages. The last stage is the
  // level that is safe to use.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= raw_switch;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sw_q, sw_d;
    logic          chg_q, chg_d;
    logic          in_bit;

    assign in_bit = sync[i];

    // Next state: count while the synchronised level disagrees with the
    // accepted level. Drop out on a bounce back, and accept at the window end.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      chg_d   = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (in_bit != sw_q) begin
            state_d = COUNT;
            cnt_d   = CNT_ONE;
          end
        end
        COUNT: begin
          if (in_bit == sw_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            sw_d    = in_bit;
            chg_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // State, counter, accepted level and strobe registers.
    always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sw_q    <= RESET_VALUE[i];
        chg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sw_q    <= sw_d;
        chg_q   <= chg_d;
      end
    end

    assign switch[i]  = sw_q;
    assign changed[i] = chg_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    // Edge strobes share the timing of `changed`, split by the new level.
    always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= chg_d & sw_d;
        fall_q <= chg_d & ~sw_d;
      end
    end

    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed, table-driven bench for switch_debouncer with
// STABLE_CYCLES=8, SYNC_STAGES=2, WIDTH=4 and RESET_VALUE=0.
// Each record holds one input level for `hold` clocks. Edge 1 of a record is
// the first edge that samples its level. `pulse_at` is the edge after which
// `changed` pulses and `switch` takes `exp_switch`; -1 means no acceptance.
module tb_switch_debouncer;

  localparam int W = 4;

  logic         clock;
  logic         n_reset;
  logic [W-1:0] raw_switch;
  logic [W-1:0] switch;
  logic [W-1:0] changed;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [W-1:0] rise;
  logic [W-1:0] fall;
`endif

  typedef struct {
    logic         do_reset;
    logic [W-1:0] raw;
    int           hold;
    int           pulse_at;
    logic [W-1:0] exp_changed;
    logic [W-1:0] exp_switch;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_miss = 0;

  switch_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (2),
    .RESET_VALUE  (4'b0000)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .raw_switch(raw_switch),
    .switch    (switch),
    .changed   (changed)
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    .rise      (rise),
    .fall      (fall)
`endif
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] e_sw,
                               input logic [W-1:0] e_chg, input logic [W-1:0] e_rise,
                               input logic [W-1:0] e_fall);
    check({tag, " switch"}, switch, e_sw);
    check({tag, " changed"}, changed, e_chg);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    check({tag, " rise"}, rise, e_rise);
    check({tag, " fall"}, fall, e_fall);
`else
    if (e_rise !== e_fall) begin
      // Edge outputs do not exist in this build; the expected values are unused.
    end
`endif
  endtask

  initial begin
    logic [W-1:0] exp_prev, e_sw, e_chg, e_rise, e_fall;

    // Reset-release acceptance, then release of all bits.
    vecs[0]  = '{1'b0, 4'b1111, 14, 11, 4'b1111, 4'b1111};
    vecs[1]  = '{1'b0, 4'b0000, 14, 11, 4'b1111, 4'b0000};
    // Clean press and release of bit 0.
    vecs[2]  = '{1'b0, 4'b0001, 14, 11, 4'b0001, 4'b0001};
    vecs[3]  = '{1'b0, 4'b0000, 14, 11, 4'b0001, 4'b0000};
    // Bounce on bit 1: high 5, low 3, high 7, then low for 20.
    vecs[4]  = '{1'b0, 4'b0010,  5, -1, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000,  3, -1, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0010,  7, -1, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 20, -1, 4'b0000, 4'b0000};
    // Independent bits: bit 2 at t, bit 3 at t+3; pulses at t+11 and t+14.
    vecs[8]  = '{1'b0, 4'b0100,  3, -1, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1100,  8,  8, 4'b0100, 4'b0100};
    vecs[10] = '{1'b0, 4'b1100, 10,  3, 4'b1000, 4'b1100};
    // Bit 2 released while bit 3 stays held.
    vecs[11] = '{1'b0, 4'b1000, 14, 11, 4'b0100, 4'b1000};
    // Bit 0 high for 6 cycles, then a one-cycle reset that discards the count.
    vecs[12] = '{1'b0, 4'b1001,  6, -1, 4'b0000, 4'b1000};
    vecs[13] = '{1'b1, 4'b1001, 14, 11, 4'b1001, 4'b1001};
    // Bit 3 release, press, release, each held 20 cycles.
    vecs[14] = '{1'b0, 4'b0001, 20, 11, 4'b1000, 4'b0001};
    vecs[15] = '{1'b0, 4'b1001, 20, 11, 4'b1000, 4'b1001};
    vecs[16] = '{1'b0, 4'b0001, 20, 11, 4'b1000, 4'b0001};

    // Reset held with all pins high: the outputs stay at the reset value.
    n_reset    = 1'b0;
    raw_switch = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      check_outputs($sformatf("reset c%0d", c), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    n_reset  = 1'b1;
    exp_prev = 4'b0000;

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].do_reset) begin
        n_reset = 1'b0;
        #1;
        check_outputs($sformatf("v%0d in-reset", v), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        @(posedge clock);
        #1;
        check_outputs($sformatf("v%0d reset-edge", v), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        n_reset  = 1'b1;
        exp_prev = 4'b0000;
      end
      raw_switch = vecs[v].raw;
      for (int k = 1; k <= vecs[v].hold; k++) begin
        @(posedge clock);
        @(negedge clock);
        e_sw   = (vecs[v].pulse_at > 0 && k >= vecs[v].pulse_at) ? vecs[v].exp_switch : exp_prev;
        e_chg  = (k == vecs[v].pulse_at) ? vecs[v].exp_changed : 4'b0000;
        e_rise = e_chg & vecs[v].exp_switch;
        e_fall = e_chg & ~vecs[v].exp_switch;
        check_outputs($sformatf("v%0d c%0d", v, k), e_sw, e_chg, e_rise, e_fall);
      end
      exp_prev = vecs[v].exp_switch;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
